// File: rtl/sect_reg_decode_gen_if.sv
// Bus bundle for the sector-register / Y-address decode block.
// The master side drives HOP/EXM/access/interrupt controls; the slave side
// returns the Y-sector select, committed sector state and stack status.
interface sect_reg_decode_gen_if #(
    parameter int unsigned SECT_W = 3,
    parameter int unsigned EXM_W  = 2
);
    localparam int unsigned N = 2**SECT_W;

    logic              HOP_LD;
    logic [SECT_W-1:0] HOP_IS;
    logic [SECT_W-1:0] HOP_DS;
    logic              HOP_PAD;
    logic              COMMIT;
    logic              EXM_LD;
    logic              EXM_EN;
    logic [EXM_W-1:0]  EXM_SEL;
    logic              ACC_REQ;
    logic              ACC_DATA;
    logic              A9;
    logic              INT_SAVE;
    logic              INT_RESTORE;
    logic              ERR_CLR;
    logic [N-1:0]      AYN;
    logic              AY_VALID;
    logic [SECT_W-1:0] IS;
    logic [SECT_W-1:0] DS;
    logic              PAD;
    logic              EXMD;
    logic              STK_EMPTY;
    logic              STK_FULL;
    logic              STK_ERR;

    modport master (
        output HOP_LD, HOP_IS, HOP_DS, HOP_PAD, COMMIT, EXM_LD, EXM_EN, EXM_SEL,
               ACC_REQ, ACC_DATA, A9, INT_SAVE, INT_RESTORE, ERR_CLR,
        input  AYN, AY_VALID, IS, DS, PAD, EXMD, STK_EMPTY, STK_FULL, STK_ERR
    );

    modport slave (
        input  HOP_LD, HOP_IS, HOP_DS, HOP_PAD, COMMIT, EXM_LD, EXM_EN, EXM_SEL,
               ACC_REQ, ACC_DATA, A9, INT_SAVE, INT_RESTORE, ERR_CLR,
        output AYN, AY_VALID, IS, DS, PAD, EXMD, STK_EMPTY, STK_FULL, STK_ERR
    );
endinterface

// File: rtl/sect_reg_decode_gen.sv
// Sector registers (IS/DS/PAD/EXMD), staged HOP loads committed at end of
// instruction, a nested interrupt context stack, and a registered active-low
// one-hot Y-sector select produced for every memory access request.
module sect_reg_decode_gen #(
    parameter int unsigned SECT_W = 3,
    parameter int unsigned EXM_W  = 2,
    parameter int unsigned DEPTH  = 2
) (
    input logic                  CLK,
    input logic                  RESET,
    sect_reg_decode_gen_if.slave bus
);
    localparam int unsigned N    = 2**SECT_W;
    localparam int unsigned SP_W = $clog2(DEPTH + 1);
    // Extended-memory sectors occupy the top 2**EXM_W decode lines.
    localparam logic [SECT_W-1:0] EXM_BASE = SECT_W'(N - 2**EXM_W);

    typedef struct packed {
        logic [SECT_W-1:0] is_v;
        logic [SECT_W-1:0] ds_v;
        logic              pad_v;
        logic              exmd_v;
        logic [EXM_W-1:0]  sel_v;
    } ctx_t;

    logic [SECT_W-1:0] is_q, is_d, ds_q, ds_d;
    logic              pad_q, pad_d, exmd_q, exmd_d;
    logic [EXM_W-1:0]  exsel_q, exsel_d;
    logic [SECT_W-1:0] stg_is_q, stg_is_d, stg_ds_q, stg_ds_d;
    logic              stg_pad_q, stg_pad_d, stg_vld_q, stg_vld_d;
    logic [N-1:0]      ayn_q, ayn_d;
    logic              ay_valid_q, ay_valid_d;
    logic              err_q, err_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    ctx_t              stk_q [DEPTH];
    ctx_t              stk_d [DEPTH];

    logic              stk_empty, stk_full;
    logic              save_only, restore_only, fault;
    ctx_t              cur, top;
    logic [SECT_W-1:0] idx;

    assign stk_empty    = (sp_q == '0);
    assign stk_full     = (sp_q == SP_W'(DEPTH));
    assign save_only    = bus.INT_SAVE & ~bus.INT_RESTORE;
    assign restore_only = bus.INT_RESTORE & ~bus.INT_SAVE;

    // Next-state: stack ops take precedence over HOP/COMMIT; decode uses current regs.
    always_comb begin
        is_d       = is_q;
        ds_d       = ds_q;
        pad_d      = pad_q;
        exmd_d     = exmd_q;
        exsel_d    = exsel_q;
        stg_is_d   = stg_is_q;
        stg_ds_d   = stg_ds_q;
        stg_pad_d  = stg_pad_q;
        stg_vld_d  = stg_vld_q;
        sp_d       = sp_q;
        stk_d      = stk_q;
        ayn_d      = ayn_q;
        ay_valid_d = 1'b0;
        fault      = bus.INT_SAVE & bus.INT_RESTORE;
        cur        = {is_q, ds_q, pad_q, exmd_q, exsel_q};
        top        = stk_q[0];
        idx        = ds_q;

        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sp_q == SP_W'(i + 1)) top = stk_q[i];
        end

        if (restore_only) begin
            if (stk_empty) begin
                fault = 1'b1;
            end else begin
                is_d      = top.is_v;
                ds_d      = top.ds_v;
                pad_d     = top.pad_v;
                exmd_d    = top.exmd_v;
                exsel_d   = top.sel_v;
                stg_vld_d = 1'b0;
                sp_d      = sp_q - SP_W'(1);
            end
        end else begin
            if (save_only) begin
                // Push is taken from the current registers, so a same-cycle
                // COMMIT is dropped and a same-cycle EXM_LD lands after it.
                if (stk_full) begin
                    fault = 1'b1;
                end else begin
                    for (int unsigned i = 0; i < DEPTH; i++) begin
                        if (sp_q == SP_W'(i)) stk_d[i] = cur;
                    end
                    sp_d = sp_q + SP_W'(1);
                end
                stg_vld_d = 1'b0;
            end else if (bus.HOP_LD && bus.COMMIT) begin
                is_d      = bus.HOP_IS;
                ds_d      = bus.HOP_DS;
                pad_d     = bus.HOP_PAD;
                stg_vld_d = 1'b0;
            end else if (bus.HOP_LD) begin
                stg_is_d  = bus.HOP_IS;
                stg_ds_d  = bus.HOP_DS;
                stg_pad_d = bus.HOP_PAD;
                stg_vld_d = 1'b1;
            end else if (bus.COMMIT && stg_vld_q) begin
                is_d      = stg_is_q;
                ds_d      = stg_ds_q;
                pad_d     = stg_pad_q;
                stg_vld_d = 1'b0;
            end
            if (bus.EXM_LD) begin
                exmd_d  = bus.EXM_EN;
                exsel_d = bus.EXM_SEL;
            end
        end

        err_d = fault ? 1'b1 : (bus.ERR_CLR ? 1'b0 : err_q);

        if (!bus.ACC_DATA)  idx = is_q;
        else if (exmd_q)    idx = EXM_BASE + SECT_W'(exsel_q);
        else if (pad_q)     idx = is_q;
        else if (bus.A9)    idx = SECT_W'(N - 1);

        if (bus.ACC_REQ) begin
            ayn_d      = ~(N'(1) << idx);
            ay_valid_d = 1'b1;
        end
    end

    // State registers with asynchronous reset, including the context stack.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            is_q       <= '0;
            ds_q       <= '0;
            pad_q      <= 1'b0;
            exmd_q     <= 1'b0;
            exsel_q    <= '0;
            stg_is_q   <= '0;
            stg_ds_q   <= '0;
            stg_pad_q  <= 1'b0;
            stg_vld_q  <= 1'b0;
            ayn_q      <= '1;
            ay_valid_q <= 1'b0;
            err_q      <= 1'b0;
            sp_q       <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) stk_q[i] <= '0;
        end else begin
            is_q       <= is_d;
            ds_q       <= ds_d;
            pad_q      <= pad_d;
            exmd_q     <= exmd_d;
            exsel_q    <= exsel_d;
            stg_is_q   <= stg_is_d;
            stg_ds_q   <= stg_ds_d;
            stg_pad_q  <= stg_pad_d;
            stg_vld_q  <= stg_vld_d;
            ayn_q      <= ayn_d;
            ay_valid_q <= ay_valid_d;
            err_q      <= err_d;
            sp_q       <= sp_d;
            stk_q      <= stk_d;
        end
    end

    assign bus.AYN       = ayn_q;
    assign bus.AY_VALID  = ay_valid_q;
    assign bus.IS        = is_q;
    assign bus.DS        = ds_q;
    assign bus.PAD       = pad_q;
    assign bus.EXMD      = exmd_q;
    assign bus.STK_EMPTY = stk_empty;
    assign bus.STK_FULL  = stk_full;
    assign bus.STK_ERR   = err_q;
endmodule

// File: tb/tb_sect_reg_decode_gen.sv
// Bench for sect_reg_decode_gen: directed scenarios with constant expectations,
// then randomized traffic against a queue-based behavioural model.
module tb_sect_reg_decode_gen;
    localparam int unsigned SECT_W = 3;
    localparam int unsigned EXM_W  = 2;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned N      = 2**SECT_W;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    sect_reg_decode_gen_if #(.SECT_W(SECT_W), .EXM_W(EXM_W)) bus ();
    sect_reg_decode_gen #(.SECT_W(SECT_W), .EXM_W(EXM_W), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {int is_v; int ds_v; int pad_v; int exmd_v; int sel_v;} ctx_t;
    ctx_t m_stk[$];
    int m_is, m_ds, m_pad, m_exmd, m_sel, m_sv, m_sis, m_sds, m_spad, m_err, m_ayn, m_av;

    task automatic clr_inputs();
        bus.HOP_LD = 0; bus.HOP_IS = '0; bus.HOP_DS = '0; bus.HOP_PAD = 0;
        bus.COMMIT = 0; bus.EXM_LD = 0; bus.EXM_EN = 0; bus.EXM_SEL = '0;
        bus.ACC_REQ = 0; bus.ACC_DATA = 0; bus.A9 = 0;
        bus.INT_SAVE = 0; bus.INT_RESTORE = 0; bus.ERR_CLR = 0;
    endtask

    task automatic model_reset();
        m_is = 0; m_ds = 0; m_pad = 0; m_exmd = 0; m_sel = 0;
        m_sv = 0; m_sis = 0; m_sds = 0; m_spad = 0; m_err = 0;
        m_ayn = (1 << N) - 1; m_av = 0;
        m_stk.delete();
    endtask

    // Apply one clock with the currently driven inputs; the model follows the rules.
    task automatic tick();
        int n_is = m_is, n_ds = m_ds, n_pad = m_pad, n_exmd = m_exmd, n_sel = m_sel;
        int n_sv = m_sv, n_sis = m_sis, n_sds = m_sds, n_spad = m_spad;
        int n_err = m_err, n_ayn = m_ayn, n_av = 0, idx = 0;
        bit sv = bus.INT_SAVE, rs = bus.INT_RESTORE, fault = (sv && rs);
        ctx_t c;
        if (bus.ACC_REQ) begin
            if (!bus.ACC_DATA)   idx = m_is;
            else if (m_exmd != 0) idx = N - (1 << EXM_W) + m_sel;
            else if (m_pad != 0)  idx = m_is;
            else if (bus.A9)      idx = N - 1;
            else                  idx = m_ds;
            n_ayn = ((1 << N) - 1) - (1 << idx);
            n_av  = 1;
        end
        if (rs && !sv) begin
            if (m_stk.size() == 0) fault = 1;
            else begin
                c = m_stk.pop_back();
                n_is = c.is_v; n_ds = c.ds_v; n_pad = c.pad_v; n_exmd = c.exmd_v; n_sel = c.sel_v;
                n_sv = 0;
            end
        end else begin
            if (sv && !rs) begin
                if (m_stk.size() == DEPTH) fault = 1;
                else m_stk.push_back('{m_is, m_ds, m_pad, m_exmd, m_sel});
                n_sv = 0;
            end else if (bus.HOP_LD && bus.COMMIT) begin
                n_is = bus.HOP_IS; n_ds = bus.HOP_DS; n_pad = bus.HOP_PAD; n_sv = 0;
            end else if (bus.HOP_LD) begin
                n_sis = bus.HOP_IS; n_sds = bus.HOP_DS; n_spad = bus.HOP_PAD; n_sv = 1;
            end else if (bus.COMMIT && m_sv != 0) begin
                n_is = m_sis; n_ds = m_sds; n_pad = m_spad; n_sv = 0;
            end
            if (bus.EXM_LD) begin
                n_exmd = bus.EXM_EN; n_sel = bus.EXM_SEL;
            end
        end
        if (fault) n_err = 1;
        else if (bus.ERR_CLR) n_err = 0;
        @(posedge CLK); #1;
        m_is = n_is; m_ds = n_ds; m_pad = n_pad; m_exmd = n_exmd; m_sel = n_sel;
        m_sv = n_sv; m_sis = n_sis; m_sds = n_sds; m_spad = n_spad;
        m_err = n_err; m_ayn = n_ayn; m_av = n_av;
        clr_inputs();
    endtask

    task automatic hop(input int is_v, input int ds_v, input int pad_v, input bit commit);
        bus.HOP_LD = 1; bus.HOP_IS = SECT_W'(is_v); bus.HOP_DS = SECT_W'(ds_v);
        bus.HOP_PAD = pad_v[0]; bus.COMMIT = commit;
    endtask

    task automatic test_reset();
        checks++; if (bus.AYN !== 8'hFF) begin errors++; $display("FAIL reset_ayn got %h want ff", bus.AYN); end
        checks++; if (bus.AY_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.AY_VALID); end
        checks++; if (bus.IS !== 3'd0 || bus.DS !== 3'd0) begin errors++; $display("FAIL reset_is_ds got %0d/%0d want 0/0", bus.IS, bus.DS); end
        checks++; if (bus.PAD !== 1'b0 || bus.EXMD !== 1'b0) begin errors++; $display("FAIL reset_pad_exmd got %b/%b want 0/0", bus.PAD, bus.EXMD); end
        checks++; if (bus.STK_EMPTY !== 1'b1 || bus.STK_FULL !== 1'b0 || bus.STK_ERR !== 1'b0) begin
            errors++; $display("FAIL reset_stack got e%b f%b err%b want e1 f0 err0", bus.STK_EMPTY, bus.STK_FULL, bus.STK_ERR); end
    endtask

    task automatic test_fetch();
        bus.ACC_REQ = 1; tick();
        checks++; if (bus.AYN !== 8'hFE) begin errors++; $display("FAIL fetch_ayn got %h want fe", bus.AYN); end
        checks++; if (bus.AY_VALID !== 1'b1) begin errors++; $display("FAIL fetch_valid got %b want 1", bus.AY_VALID); end
        tick();
        checks++; if (bus.AY_VALID !== 1'b0) begin errors++; $display("FAIL valid_pulse got %b want 0", bus.AY_VALID); end
        checks++; if (bus.AYN !== 8'hFE) begin errors++; $display("FAIL ayn_hold got %h want fe", bus.AYN); end
    endtask

    task automatic test_hop_decode();
        hop(5, 2, 0, 0); tick();
        checks++; if (bus.IS !== 3'd0) begin errors++; $display("FAIL staged_not_applied got %0d want 0", bus.IS); end
        bus.ACC_REQ = 1; bus.ACC_DATA = 1; tick();
        checks++; if (bus.AYN !== 8'hFE) begin errors++; $display("FAIL data_pre_commit got %h want fe", bus.AYN); end
        bus.COMMIT = 1; tick();
        checks++; if (bus.IS !== 3'd5 || bus.DS !== 3'd2) begin errors++; $display("FAIL commit_is_ds got %0d/%0d want 5/2", bus.IS, bus.DS); end
        bus.ACC_REQ = 1; bus.ACC_DATA = 1; tick();
        checks++; if (bus.AYN !== 8'hFB) begin errors++; $display("FAIL data_ds got %h want fb", bus.AYN); end
        bus.ACC_REQ = 1; tick();
        checks++; if (bus.AYN !== 8'hDF) begin errors++; $display("FAIL fetch_is got %h want df", bus.AYN); end
        bus.ACC_REQ = 1; bus.ACC_DATA = 1; bus.A9 = 1; tick();
        checks++; if (bus.AYN !== 8'h7F) begin errors++; $display("FAIL residual got %h want 7f", bus.AYN); end
        hop(5, 2, 1, 1); tick();
        bus.ACC_REQ = 1; bus.ACC_DATA = 1; bus.A9 = 1; tick();
        checks++; if (bus.AYN !== 8'hDF) begin errors++; $display("FAIL pad_over_a9 got %h want df", bus.AYN); end
        bus.EXM_LD = 1; bus.EXM_EN = 1; bus.EXM_SEL = 2'd2; tick();
        checks++; if (bus.EXMD !== 1'b1) begin errors++; $display("FAIL exmd_load got %b want 1", bus.EXMD); end
        bus.ACC_REQ = 1; bus.ACC_DATA = 1; tick();
        checks++; if (bus.AYN !== 8'hBF) begin errors++; $display("FAIL exm_index got %h want bf", bus.AYN); end
    endtask

    task automatic test_bypass();
        hop(3, 2, 0, 1); bus.EXM_LD = 1; tick();
        checks++; if (bus.IS !== 3'd3 || bus.PAD !== 1'b0 || bus.EXMD !== 1'b0) begin
            errors++; $display("FAIL bypass got is%0d pad%b exmd%b want is3 pad0 exmd0", bus.IS, bus.PAD, bus.EXMD); end
        bus.COMMIT = 1; tick();
        checks++; if (bus.IS !== 3'd3) begin errors++; $display("FAIL commit_no_stage got %0d want 3", bus.IS); end
        hop(6, 2, 0, 0); tick();
        hop(4, 2, 0, 0); tick();
        bus.COMMIT = 1; tick();
        checks++; if (bus.IS !== 3'd4) begin errors++; $display("FAIL stage_overwrite got %0d want 4", bus.IS); end
        hop(3, 2, 0, 1); tick();
    endtask

    task automatic test_stack();
        bus.INT_SAVE = 1; tick();
        checks++; if (bus.STK_EMPTY !== 1'b0 || bus.STK_FULL !== 1'b0) begin errors++; $display("FAIL push1 got e%b f%b want e0 f0", bus.STK_EMPTY, bus.STK_FULL); end
        hop(1, 2, 0, 1); tick();
        bus.INT_SAVE = 1; tick();
        checks++; if (bus.STK_FULL !== 1'b1) begin errors++; $display("FAIL push2_full got %b want 1", bus.STK_FULL); end
        bus.INT_SAVE = 1; tick();
        checks++; if (bus.STK_ERR !== 1'b1 || bus.STK_FULL !== 1'b1) begin errors++; $display("FAIL overflow got err%b f%b want err1 f1", bus.STK_ERR, bus.STK_FULL); end
        bus.INT_RESTORE = 1; tick();
        checks++; if (bus.IS !== 3'd1) begin errors++; $display("FAIL pop1 got %0d want 1", bus.IS); end
        bus.INT_RESTORE = 1; tick();
        checks++; if (bus.IS !== 3'd3 || bus.STK_EMPTY !== 1'b1) begin errors++; $display("FAIL pop2 got is%0d e%b want is3 e1", bus.IS, bus.STK_EMPTY); end
        bus.INT_RESTORE = 1; tick();
        checks++; if (bus.IS !== 3'd3 || bus.STK_ERR !== 1'b1) begin errors++; $display("FAIL underflow got is%0d err%b want is3 err1", bus.IS, bus.STK_ERR); end
        bus.ERR_CLR = 1; tick();
        checks++; if (bus.STK_ERR !== 1'b0) begin errors++; $display("FAIL err_clr got %b want 0", bus.STK_ERR); end
        hop(7, 2, 0, 0); tick();
        bus.INT_SAVE = 1; tick();
        bus.COMMIT = 1; tick();
        checks++; if (bus.IS !== 3'd3) begin errors++; $display("FAIL save_discards_stage got %0d want 3", bus.IS); end
        bus.INT_RESTORE = 1; tick();
    endtask

    task automatic test_simultaneous();
        bus.INT_SAVE = 1; tick();
        bus.INT_SAVE = 1; bus.INT_RESTORE = 1; tick();
        checks++; if (bus.STK_ERR !== 1'b1 || bus.STK_EMPTY !== 1'b0 || bus.STK_FULL !== 1'b0) begin
            errors++; $display("FAIL save_restore got err%b e%b f%b want err1 e0 f0", bus.STK_ERR, bus.STK_EMPTY, bus.STK_FULL); end
        bus.INT_SAVE = 1; bus.INT_RESTORE = 1; bus.ERR_CLR = 1; tick();
        checks++; if (bus.STK_ERR !== 1'b1) begin errors++; $display("FAIL fault_beats_clr got %b want 1", bus.STK_ERR); end
        bus.ERR_CLR = 1; tick();
        hop(6, 2, 0, 0); tick();
        bus.INT_SAVE = 1; bus.COMMIT = 1; tick();
        checks++; if (bus.IS !== 3'd3 || bus.STK_FULL !== 1'b1) begin errors++; $display("FAIL save_drops_commit got is%0d f%b want is3 f1", bus.IS, bus.STK_FULL); end
        hop(2, 2, 0, 1); tick();
        hop(5, 2, 0, 1); bus.INT_RESTORE = 1; bus.EXM_LD = 1; bus.EXM_EN = 1; tick();
        checks++; if (bus.IS !== 3'd3 || bus.EXMD !== 1'b0) begin errors++; $display("FAIL restore_wins got is%0d exmd%b want is3 exmd0", bus.IS, bus.EXMD); end
        bus.INT_RESTORE = 1; tick();
        bus.INT_SAVE = 1; bus.EXM_LD = 1; bus.EXM_EN = 1; bus.EXM_SEL = 2'd1; tick();
        checks++; if (bus.EXMD !== 1'b1) begin errors++; $display("FAIL exm_with_save got %b want 1", bus.EXMD); end
        bus.INT_RESTORE = 1; tick();
        checks++; if (bus.EXMD !== 1'b0 || bus.STK_EMPTY !== 1'b1) begin errors++; $display("FAIL pushed_pre_load got exmd%b e%b want exmd0 e1", bus.EXMD, bus.STK_EMPTY); end
    endtask

    task automatic test_reset_mid();
        hop(6, 4, 1, 1); tick();
        bus.INT_SAVE = 1; bus.ACC_REQ = 1; tick();
        RESET = 1'b1; #1;
        checks++; if (bus.AYN !== 8'hFF || bus.AY_VALID !== 1'b0) begin errors++; $display("FAIL midreset_ayn got %h/%b want ff/0", bus.AYN, bus.AY_VALID); end
        checks++; if (bus.IS !== 3'd0 || bus.DS !== 3'd0 || bus.PAD !== 1'b0) begin errors++; $display("FAIL midreset_regs got %0d/%0d/%b want 0/0/0", bus.IS, bus.DS, bus.PAD); end
        checks++; if (bus.STK_EMPTY !== 1'b1 || bus.STK_ERR !== 1'b0) begin errors++; $display("FAIL midreset_stack got e%b err%b want e1 err0", bus.STK_EMPTY, bus.STK_ERR); end
        @(negedge CLK); RESET = 1'b0;
        model_reset();
        @(posedge CLK); #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bus.HOP_LD = ($urandom_range(0, 9) < 3); bus.HOP_IS = SECT_W'($urandom);
            bus.HOP_DS = SECT_W'($urandom); bus.HOP_PAD = ($urandom_range(0, 3) == 0);
            bus.COMMIT = ($urandom_range(0, 9) < 3); bus.EXM_LD = ($urandom_range(0, 9) == 0);
            bus.EXM_EN = ($urandom_range(0, 2) == 0); bus.EXM_SEL = EXM_W'($urandom);
            bus.ACC_REQ = ($urandom_range(0, 1) == 1); bus.ACC_DATA = ($urandom_range(0, 3) != 0);
            bus.A9 = ($urandom_range(0, 1) == 1); bus.INT_SAVE = ($urandom_range(0, 9) == 0);
            bus.INT_RESTORE = ($urandom_range(0, 9) == 0); bus.ERR_CLR = ($urandom_range(0, 9) == 0);
            tick();
            checks++; if (bus.AYN !== N'(m_ayn)) begin errors++; $display("FAIL rnd_ayn cyc %0d got %h want %h", n, bus.AYN, N'(m_ayn)); end
            checks++; if (bus.AY_VALID !== 1'(m_av)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b want %0d", n, bus.AY_VALID, m_av); end
            checks++; if (bus.IS !== SECT_W'(m_is)) begin errors++; $display("FAIL rnd_is cyc %0d got %0d want %0d", n, bus.IS, m_is); end
            checks++; if (bus.DS !== SECT_W'(m_ds)) begin errors++; $display("FAIL rnd_ds cyc %0d got %0d want %0d", n, bus.DS, m_ds); end
            checks++; if (bus.PAD !== 1'(m_pad)) begin errors++; $display("FAIL rnd_pad cyc %0d got %b want %0d", n, bus.PAD, m_pad); end
            checks++; if (bus.EXMD !== 1'(m_exmd)) begin errors++; $display("FAIL rnd_exmd cyc %0d got %b want %0d", n, bus.EXMD, m_exmd); end
            checks++; if (bus.STK_EMPTY !== (m_stk.size() == 0)) begin errors++; $display("FAIL rnd_empty cyc %0d got %b want %0d", n, bus.STK_EMPTY, m_stk.size() == 0); end
            checks++; if (bus.STK_FULL !== (m_stk.size() == DEPTH)) begin errors++; $display("FAIL rnd_full cyc %0d got %b want %0d", n, bus.STK_FULL, m_stk.size() == DEPTH); end
            checks++; if (bus.STK_ERR !== 1'(m_err)) begin errors++; $display("FAIL rnd_err cyc %0d got %b want %0d", n, bus.STK_ERR, m_err); end
        end
    endtask

    initial begin
        RESET = 1'b1;
        clr_inputs();
        model_reset();
        #12 RESET = 1'b0;
        @(posedge CLK); #1;
        test_reset();
        test_fetch();
        test_hop_decode();
        test_bypass();
        test_stack();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sect_reg_decode_gen.md
Name: sect_reg_decode_gen

Overview:
- Parametrised successor to the LVDC sector-register/Y-address decode logic.
- Holds the instruction sector (IS), data sector (DS), residual/PAD flag and extended-memory mode (EXMD).
- Takes staged HOP loads, committed at end of instruction, plus a nested interrupt save/restore stack.
- Produces a registered, active-low, one-hot memory Y-sector select per access request.

Parameters:
SECT_W, 3, sector field width; N = 2**SECT_W decode lines
EXM_W, 2, extended-memory select width; EXM_W <= SECT_W
DEPTH, 2, interrupt save-stack depth (>=1)

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-high reset
HOP_LD  in  1  stage HOP_IS/HOP_DS/HOP_PAD
HOP_IS  in  SECT_W  new instruction sector
HOP_DS  in  SECT_W  new data sector
HOP_PAD  in  1  new PAD flag
COMMIT  in  1  end-of-instruction; apply staged HOP
EXM_LD  in  1  load extended-memory mode/select
EXM_EN  in  1  new EXMD value
EXM_SEL  in  EXM_W  new extended-memory select
ACC_REQ  in  1  memory access request
ACC_DATA  in  1  1 = data access, 0 = instruction fetch
A9  in  1  operand address bit 9 (residual-sector request)
INT_SAVE  in  1  push context
INT_RESTORE  in  1  pop context
ERR_CLR  in  1  clear STK_ERR
AYN  out  N  active-low one-hot Y-sector select
AY_VALID  out  1  one-cycle pulse, AYN updated
IS  out  SECT_W  committed instruction sector
DS  out  SECT_W  committed data sector
PAD  out  1  committed PAD flag
EXMD  out  1  extended-memory mode
STK_EMPTY  out  1  stack empty
STK_FULL  out  1  stack holds DEPTH entries
STK_ERR  out  1  sticky stack fault

Behaviour:
- Reset (async):
  - IS, DS, PAD, EXMD and the EXM select register = 0.
  - Staged-valid = 0; stack empty.
  - AYN = all ones; AY_VALID = 0; STK_ERR = 0.
- HOP staging:
  - HOP_LD captures the HOP fields into the stage register and sets staged-valid.
  - A repeated HOP_LD overwrites the stage.
- Commit:
  - COMMIT with staged-valid copies stage to IS/DS/PAD and clears staged-valid.
  - COMMIT with HOP_LD in the same cycle bypasses: the HOP inputs are committed directly and staged-valid ends 0.
  - COMMIT without staged-valid and without HOP_LD: no change.
- EXM_LD: EXMD <= EXM_EN and EXM select <= EXM_SEL next edge; independent of commit.
- Sector index on ACC_REQ, priority order:
  - Instruction access: index = IS.
  - Data access, EXMD=1: index = N - 2**EXM_W + EXM select.
  - Data access, else PAD=1: index = IS.
  - Data access, else A9=1: index = N-1 (residual sector).
  - Data access, otherwise: index = DS.
- Decode timing:
  - Decode uses register values before any same-cycle update.
  - AYN[index] = 0, all other bits 1, registered one cycle after ACC_REQ.
  - AY_VALID pulses high in that same cycle.
  - AYN holds its value until the next ACC_REQ; exactly one bit is ever low after the first access.
- INT_SAVE:
  - Pushes {IS, DS, PAD, EXMD, EXM select}.
  - Staged HOP is discarded; committed state is unchanged.
  - When full: no push, STK_ERR <= 1.
- INT_RESTORE:
  - Pops the top entry into IS/DS/PAD/EXMD/EXM select and clears staged-valid.
  - When empty: no change, STK_ERR <= 1.
- Simultaneous events:
  - INT_SAVE and INT_RESTORE together: no stack operation, STK_ERR <= 1.
  - RESTORE beats COMMIT, HOP_LD and EXM_LD in the same cycle; those are ignored.
  - SAVE beats a same-cycle COMMIT: the pushed context is pre-commit and the commit is dropped.
  - EXM_LD with SAVE: the push is pre-load, then the load applies.
- STK_ERR clears on ERR_CLR unless a new fault occurs that cycle; the fault wins.
- STK_EMPTY and STK_FULL are combinational from the stack pointer.
- Reset mid-operation returns all state, including the stack, to reset values immediately.

Test Plan:
- Reset -> AYN=8'hFF, AY_VALID=0, IS=DS=0, STK_EMPTY=1. Then ACC_REQ with ACC_DATA=0 -> next cycle AYN=8'hFE, AY_VALID=1 for one cycle.
- HOP_LD IS=5, DS=2, PAD=0, no COMMIT -> data access gives AYN=8'hFE. COMMIT, then data access with A9=0 -> AYN=8'hFB; instruction fetch -> AYN=8'hDF.
- Data access with A9=1, PAD=0 -> AYN=8'h7F. Set PAD=1 via HOP+COMMIT (IS=5) -> data access gives AYN=8'hDF. EXM_LD EN=1, SEL=2 -> data access gives index 6, AYN=8'hBF.
- HOP_LD+COMMIT same cycle with IS=3 -> IS=3 next cycle, staged-valid=0. A following COMMIT alone leaves IS=3.
- Interrupt stack with DEPTH=2:
  - Save (IS=3), commit IS=1, save, third save -> STK_FULL=1, STK_ERR=1.
  - Restore twice -> IS=1, then IS=3; third restore keeps IS=3, STK_ERR=1.
  - ERR_CLR -> STK_ERR=0.
- Simultaneous SAVE+RESTORE -> pointer unchanged, STK_ERR=1. Assert RESET mid-sequence -> all outputs at reset values in the same cycle.
